btn_cmd_arbiter: RTL and testbench

//  Collects one-cycle command pulses from N_CMD debounced buttons and ASCII command bytes from UART RX.

---
 rtl/btn_cmd_pkg.sv | 46 ++++
 rtl/btn_cmd_arbiter_rr_pick.sv | 33 +++
 rtl/btn_cmd_arbiter.sv | 126 ++++++++++++
 tb/tb_btn_cmd_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_cmd_pkg.sv
// btn_cmd_pkg: shared constants and types for btn_cmd_arbiter.
//   - command ids (CMD_RUN..CMD_MIN)
//   - ASCII codes accepted from UART RX (both letter cases)
//   - FSM state encoding
//   - rx_map(): translates an RX byte to {hit, command id}
package btn_cmd_pkg;

  localparam int CMD_RUN  = 0;
  localparam int CMD_CLR  = 1;
  localparam int CMD_HOUR = 2;
  localparam int CMD_MIN  = 3;

  localparam logic [7:0] ASC_R_UC = 8'h52;
  localparam logic [7:0] ASC_R_LC = 8'h72;
  localparam logic [7:0] ASC_C_UC = 8'h43;
  localparam logic [7:0] ASC_C_LC = 8'h63;
  localparam logic [7:0] ASC_H_UC = 8'h48;
  localparam logic [7:0] ASC_H_LC = 8'h68;
  localparam logic [7:0] ASC_M_UC = 8'h4D;
  localparam logic [7:0] ASC_M_LC = 8'h6D;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] id;
  } rx_map_t;

  function automatic rx_map_t rx_map(input logic [7:0] b);
    rx_map_t m;
    m.hit = 1'b1;
    m.id  = 2'd0;
    case (b)
      ASC_R_UC, ASC_R_LC: m.id = 2'(CMD_RUN);
      ASC_C_UC, ASC_C_LC: m.id = 2'(CMD_CLR);
      ASC_H_UC, ASC_H_LC: m.id = 2'(CMD_HOUR);
      ASC_M_UC, ASC_M_LC: m.id = 2'(CMD_MIN);
      default:            m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/btn_cmd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin select.
//   req    : request vector, bit k = id k
//   ptr    : id with highest priority this round
//   gnt_id : first requesting id at or after ptr, wrapping at N_CMD
//   any    : at least one request present
module rr_pick #(
  parameter  int N_CMD = 4,
  localparam int ID_W  = $clog2(N_CMD)
) (
  input  logic [N_CMD-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  gnt_id,
  output logic             any
);

  int j;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    j      = 0;
    for (int i = N_CMD - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N_CMD) j = j - N_CMD;
      if (req[ID_W'(j)]) begin
        gnt_id = ID_W'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_cmd_arbiter.sv
// btn_cmd_arbiter: merges debounced button pulses and UART command bytes
// into one valid/ready command stream with round-robin fairness.
//   clk, rst      : clock, asynchronous active-low reset
//   i_btn         : 1-cycle button pulses, bit k = command k
//   i_rx_data/done: UART byte and its 1-cycle strobe
//   i_cmd_ready   : consumer accepts the presented command
//   o_cmd_valid   : command presented (registered)
//   o_cmd_id      : command index, stable while valid
//   o_rx_err      : pulse, RX byte did not map to a command
//   o_overrun     : pulse, request hit an already-pending id
//   o_drop        : pulse, command abandoned after TIMEOUT_CYC cycles
// Build option: define CMD_TIMEOUT_EN to enable the ISSUE wait timeout;
// otherwise ISSUE waits forever and o_drop is tied low.
module btn_cmd_arbiter
  import btn_cmd_pkg::*;
#(
  parameter  int N_CMD       = 4,
  parameter  int TIMEOUT_CYC = 100_000,
  localparam int ID_W        = $clog2(N_CMD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CMD-1:0] i_btn,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_done,
  input  logic             i_cmd_ready,
  output logic             o_cmd_valid,
  output logic [ID_W-1:0]  o_cmd_id,
  output logic             o_rx_err,
  output logic             o_overrun,
  output logic             o_drop
);

  if (N_CMD < 2 || N_CMD > 8 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("btn_cmd_arbiter: N_CMD must be 2..8 and TIMEOUT_CYC >= 1");
  end

  state_t            state, state_nx;
  logic [N_CMD-1:0]  pending, req, rx_req, retire_vec;
  logic [ID_W-1:0]   ptr, cmd_id, gnt_id;
  logic              gnt_any, accept, drop_now, retire, rx_ok;
  rx_map_t           rx_m;

  // RX decode; letters whose id is beyond N_CMD count as unmapped.
  assign rx_m  = rx_map(i_rx_data);
  assign rx_ok = rx_m.hit && (int'(rx_m.id) < N_CMD);

  for (genvar k = 0; k < N_CMD; k++) begin : g_rx_req
    assign rx_req[k] = i_rx_done && rx_ok && (int'(rx_m.id) == k);
  end

  // Button and RX on the same id collapse into a single request.
  assign req    = i_btn | rx_req;
  assign accept = (state == ISSUE) && i_cmd_ready;
  assign retire = accept || drop_now;

  always_comb begin
    retire_vec = '0;
    if (retire) retire_vec[cmd_id] = 1'b1;
  end

  rr_pick #(.N_CMD(N_CMD)) u_pick (
    .req    (pending),
    .ptr    (ptr),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_any) state_nx = ISSUE;
      ISSUE:   if (retire)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // A request landing on the retiring id re-arms it rather than overrunning.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending   <= '0;
      cmd_id    <= '0;
      ptr       <= '0;
      o_rx_err  <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      pending   <= (pending & ~retire_vec) | req;
      o_rx_err  <= i_rx_done && !rx_ok;
      o_overrun <= |(req & pending & ~retire_vec);
      if (state == IDLE && gnt_any) cmd_id <= gnt_id;
      if (retire) ptr <= (cmd_id == ID_W'(N_CMD - 1)) ? '0 : cmd_id + 1'b1;
    end
  end

  assign o_cmd_valid = (state == ISSUE);
  assign o_cmd_id    = cmd_id;

`ifdef CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] wait_cnt;

  // Held at zero in IDLE, so every ISSUE starts counting from zero.
  assign drop_now = (state == ISSUE) && !i_cmd_ready &&
                    (wait_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      o_drop   <= 1'b0;
    end else begin
      o_drop <= drop_now;
      if (state == IDLE)     wait_cnt <= '0;
      else if (!i_cmd_ready) wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign drop_now = 1'b0;
  assign o_drop   = 1'b0;
`endif

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
module tb_btn_cmd_arbiter;

  localparam int N = 4;
`ifdef CMD_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 100_000;
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] btn = '0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_done = 1'b0;
  logic         ready = 1'b0;
  logic         valid, rx_err, ovr, drop;
  logic [1:0]   id;

  always #5 clk = ~clk;

  btn_cmd_arbiter #(.N_CMD(N), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_btn       (btn),
    .i_rx_data   (rx_data),
    .i_rx_done   (rx_done),
    .i_cmd_ready (ready),
    .o_cmd_valid (valid),
    .o_cmd_id    (id),
    .o_rx_err    (rx_err),
    .o_overrun   (ovr),
    .o_drop      (drop)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: set of pending ids, the command in flight, a pointer.
  bit m_pend[N];
  bit m_busy;
  int m_cur, m_ptr, m_wait;
  bit e_err, e_ovr, e_drop;

  function automatic int cmd_of(input logic [7:0] b);
    string letters = "rchm";
    logic [7:0] c = b;
    if (c >= 8'h41 && c <= 8'h5A) c = c + 8'h20;
    for (int i = 0; i < 4; i++)
      if (letters[i] == c) return (i < N) ? i : -1;
    return -1;
  endfunction

  task automatic model_reset();
    foreach (m_pend[k]) m_pend[k] = 1'b0;
    m_busy = 1'b0; m_cur = 0; m_ptr = 0; m_wait = 0;
    e_err = 1'b0; e_ovr = 1'b0; e_drop = 1'b0;
  endtask

  task automatic model_edge();
    int hit, done;
    bit req[N];
    hit   = rx_done ? cmd_of(rx_data) : -1;
    e_err = rx_done && (hit < 0);
    for (int k = 0; k < N; k++) req[k] = btn[k] || (hit == k);
    done   = -1;
    e_drop = 1'b0;
    if (m_busy) begin
      if (ready) done = m_cur;
      else if (TO_EN && m_wait == TO - 1) begin
        done = m_cur; e_drop = 1'b1;
      end else m_wait++;
    end
    e_ovr = 1'b0;
    for (int k = 0; k < N; k++)
      if (req[k] && m_pend[k] && k != done) e_ovr = 1'b1;
    if (done >= 0) begin
      m_pend[done] = 1'b0; m_busy = 1'b0; m_ptr = (done + 1) % N;
    end else if (!m_busy) begin
      for (int s = 0; s < N; s++) begin
        if (m_pend[(m_ptr + s) % N]) begin
          m_busy = 1'b1; m_cur = (m_ptr + s) % N; m_wait = 0;
          break;
        end
      end
    end
    for (int k = 0; k < N; k++) if (req[k]) m_pend[k] = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_edge();
    #1;
    chk("valid", valid, m_busy);
    if (m_busy) chk("id", id, m_cur);
    chk("rx_err", rx_err, e_err);
    chk("overrun", ovr, e_ovr);
    chk("drop", drop, e_drop);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_id", id, 0);
    model_reset();
    repeat (2) step();
    rst = 1'b1;
  endtask

  logic [7:0] tbl [10] = '{8'h52, 8'h72, 8'h43, 8'h63, 8'h48,
                          8'h68, 8'h4D, 8'h6D, 8'h41, 8'h7A};

  initial begin
    int vcnt, dcnt;
    model_reset();
    repeat (2) step();
    chk("rst_id", id, 0);
    chk("rst_pulses", {rx_err, ovr, drop}, 0);
    rst = 1'b1;
    step();

    // single button, consumer always ready
    ready = 1'b1; btn = 4'b0010; step(); btn = '0;
    chk("t1_wait", valid, 0);
    step(); chk("t1_valid", valid, 1); chk("t1_id", id, 1);
    step(); chk("t1_gap", valid, 0);

    // two buttons together from a fresh pointer: 0 then 2
    do_reset();
    ready = 1'b1; btn = 4'b0101; step(); btn = '0;
    step(); chk("t2_first", {valid, id}, {1'b1, 2'd0});
    step(); chk("t2_gap", valid, 0);
    step(); chk("t2_second", {valid, id}, {1'b1, 2'd2});
    repeat (2) step(); chk("t2_done", valid, 0);

    // RX commands: 'h' maps to 2, 'A' is unmapped
    rx_data = 8'h68; rx_done = 1'b1; step(); rx_done = 1'b0;
    step(); chk("t3_h", {valid, id}, {1'b1, 2'd2});
    repeat (2) step();
    rx_data = 8'h41; rx_done = 1'b1; step(); rx_done = 1'b0;
    chk("t3_err", rx_err, 1); chk("t3_noval", valid, 0);
    repeat (2) step();

    // stalled consumer, repeated button coalesces into one overrun
    ready = 1'b0; btn = 4'b1000; step(); btn = '0;
    step(); chk("t4_valid", {valid, id}, {1'b1, 2'd3});
    btn = 4'b1000; step(); btn = '0;
    chk("t4_ovr", ovr, 1);
    repeat (TO_EN ? 4 : 8) begin
      step(); chk("t4_hold", {valid, id}, {1'b1, 2'd3});
    end
    ready = 1'b1; step();
    repeat (3) begin step(); chk("t4_once", valid, 0); end

    // reset in the middle of ISSUE
    ready = 1'b0; btn = 4'b0001; step(); btn = '0;
    step(); chk("t5_pre", valid, 1);
    #2; rst = 1'b0; #1;
    chk("t5_async", {valid, id, rx_err, ovr, drop}, 0);
    model_reset();
    repeat (2) step();
    rst = 1'b1;
    repeat (4) step();
    chk("t5_idle", valid, 0);

`ifdef CMD_TIMEOUT_EN
    // timeout: valid held TO cycles, then one drop pulse
    ready = 1'b0; btn = 4'b0100; step(); btn = '0;
    vcnt = 0; dcnt = 0;
    repeat (TO + 4) begin
      step(); vcnt += int'(valid); dcnt += int'(drop);
    end
    chk("t6_vcnt", vcnt, TO);
    chk("t6_drop", dcnt, 1);
    ready = 1'b1;
    repeat (2) step();
    chk("t6_cleared", valid, 0);
`endif

    // randomized traffic against the model
    repeat (800) begin
      btn     = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
      rx_done = ($urandom_range(0, 4) == 0);
      rx_data = $urandom_range(0, 1) ? tbl[$urandom_range(0, 9)] : 8'($urandom);
      ready   = ($urandom_range(0, 2) != 0);
      step();
    end
    btn = '0; rx_done = 1'b0; ready = 1'b1;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
